// File: rtl/srl_credit_fifo_if.sv
// Handshake bundle between an upstream delay pipeline, the credit FIFO and
// its consumer. Widths are set by the instantiating scope so that they match
// the FIFO's C_DATA_WIDTH and $clog2(C_FIFO_DEPTH+1).
interface srl_credit_fifo_if #(
  parameter int DW = 32,
  parameter int CW = 5
);
  logic          issue_req;
  logic          issue_grant;
  logic          pipe_valid;
  logic [DW-1:0] pipe_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
  logic [CW-1:0] in_flight;
  logic          err;

  // Upstream issuer / pipeline / consumer side
  modport master (
    output issue_req, pipe_valid, pipe_data, out_ready,
    input  issue_grant, out_valid, out_data, count, in_flight, err
  );

  // FIFO side
  modport slave (
    input  issue_req, pipe_valid, pipe_data, out_ready,
    output issue_grant, out_valid, out_data, count, in_flight, err
  );
endinterface

// File: rtl/srl_credit_fifo.sv
// Credit-gated output buffer for a fixed-latency, stall-free delay pipeline.
// A launch is granted only when a slot is reserved for it, so every item that
// later emerges from the pipeline is guaranteed space. Items are presented to
// the consumer first-word-fall-through on a valid/ready interface.
module srl_credit_fifo #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_FIFO_DEPTH   = 16,
  parameter int C_PIPE_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  srl_credit_fifo_if.slave  bus
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int CW = $clog2(C_FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(C_FIFO_DEPTH);

  // Reject configurations that cannot hold a full pipeline's worth of items
  // or that break natural pointer wrap.
  if (((C_FIFO_DEPTH & (C_FIFO_DEPTH - 1)) != 0) ||
      (C_FIFO_DEPTH < C_PIPE_LATENCY + 1)) begin : g_bad_cfg
    $error("srl_credit_fifo: C_FIFO_DEPTH must be a power of two >= C_PIPE_LATENCY+1");
  end

  logic [C_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count_q, count_d;
  logic [CW-1:0]           infl_q, infl_d;
  logic [CW-1:0]           credits, credits_d;
  logic                    err_q, err_d;

  logic grant, push, pop, full, empty;
  logic spurious, overflow, infl_sat;

  // Handshake decode. Grant is masked while reset is asserted.
  always_comb begin
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);
    grant    = bus.issue_req && (credits != '0) && rst;
    push     = bus.pipe_valid && !full;
    pop      = !empty && bus.out_ready;
    spurious = bus.pipe_valid && (infl_q == '0);
    overflow = bus.pipe_valid && full;
    infl_sat = grant && !bus.pipe_valid && (infl_q == DEPTH_C);
  end

  // Next-state for the three bookkeeping counters and the sticky error.
  always_comb begin
    credits_d = credits;
    count_d   = count_q;
    infl_d    = infl_q;
    err_d     = err_q | spurious | overflow | infl_sat;

    // A pop returns the slot; a grant reserves one.
    case ({grant, pop})
      2'b10:   credits_d = credits - 1'b1;
      2'b01:   credits_d = credits + 1'b1;
      default: credits_d = credits;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Saturate at both ends so a protocol error never wraps the counter.
    case ({grant, bus.pipe_valid})
      2'b10:   infl_d = infl_sat ? infl_q : infl_q + 1'b1;
      2'b01:   infl_d = (infl_q != '0) ? infl_q - 1'b1 : infl_q;
      default: infl_d = infl_q;
    endcase
  end

  // Control state: pointers, counters and error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      infl_q  <= '0;
      credits <= DEPTH_C;
      err_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_d;
      infl_q  <= infl_d;
      credits <= credits_d;
      err_q   <= err_d;
    end
  end

  // Payload storage; not cleared by reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push && rst) mem[wr_ptr] <= bus.pipe_data;
  end

  assign bus.issue_grant = grant;
  assign bus.out_valid   = !empty;
  assign bus.out_data    = mem[rd_ptr];
  assign bus.count       = count_q;
  assign bus.in_flight   = infl_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_srl_credit_fifo.sv
// Bench for srl_credit_fifo: a 4-stage delay-line model feeds the FIFO,
// granted items are queued as expected output and compared on each pop.
module tb_srl_credit_fifo;

  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int LAT = 4;
  localparam int CW  = $clog2(DEP + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  srl_credit_fifo_if #(.DW(DW), .CW(CW)) bus ();

  srl_credit_fifo #(
    .C_DATA_WIDTH(DW), .C_FIFO_DEPTH(DEP), .C_PIPE_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic req, rdy, grant, valid;
    int   cnt, infl;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;
  int n_grant = 0;
  int n_out = 0;
  int seq = 1;
  logic inv_en = 1'b0;
  logic force_pv = 1'b0;

  logic          pv [LAT];
  logic [DW-1:0] pd [LAT];
  logic [DW-1:0] sb [$];

  // Per-cycle snapshot taken before the edge, plus post-edge state.
  logic s_grant, s_valid, s_err, s_pop, s_push;
  int   s_count, s_infl, s_credits, post_credits, post_count;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] item(input int s);
    return 32'hA5A5_0000 | DW'(s);
  endfunction

  // One clock cycle: drive, sample, compare pops, advance the pipeline model.
  task automatic tick(input logic req, input logic rdy);
    logic g;
    bus.issue_req  = req;
    bus.out_ready  = rdy;
    bus.pipe_valid = force_pv ? 1'b1 : pv[LAT-1];
    bus.pipe_data  = force_pv ? 32'hDEAD_BEEF : pd[LAT-1];
    #2;
    g         = bus.issue_grant;
    s_grant   = g;
    s_valid   = bus.out_valid;
    s_err     = bus.err;
    s_count   = int'(bus.count);
    s_infl    = int'(bus.in_flight);
    s_credits = int'(dut.credits);
    s_pop     = bus.out_valid && rdy;
    s_push    = bus.pipe_valid && (s_count != DEP);
    if (s_pop && rst) begin
      if (sb.size() == 0) chk("pop_unexpected", 1, 0);
      else chk("out_data", bus.out_data, sb.pop_front());
      n_out++;
    end
    @(posedge clk);
    #1;
    post_credits = int'(dut.credits);
    post_count   = int'(bus.count);
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = g;
    pd[0] = item(seq);
    if (g) begin
      sb.push_back(item(seq));
      seq++;
      n_grant++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rst = 1'b1;
    sb.delete();
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    seq = 1;
  endtask

  // Credit conservation holds every cycle outside deliberate error injection.
  always @(negedge clk) begin
    if (inv_en && rst)
      chk("invariant", int'(dut.credits) + int'(bus.count) + int'(bus.in_flight), DEP);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    int g0, c0, out0;

    // Single item: grant in cycle 0, arrives cycle 4, visible cycle 5, popped.
    tbl[0] = '{req:1, rdy:0, grant:1, valid:0, cnt:0, infl:0};
    tbl[1] = '{req:0, rdy:0, grant:0, valid:0, cnt:0, infl:1};
    tbl[2] = '{req:0, rdy:0, grant:0, valid:0, cnt:0, infl:1};
    tbl[3] = '{req:0, rdy:0, grant:0, valid:0, cnt:0, infl:1};
    tbl[4] = '{req:0, rdy:0, grant:0, valid:0, cnt:0, infl:1};
    tbl[5] = '{req:0, rdy:1, grant:0, valid:1, cnt:1, infl:0};
    tbl[6] = '{req:0, rdy:0, grant:0, valid:0, cnt:0, infl:0};

    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    bus.issue_req = 1'b0; bus.out_ready = 1'b0;
    bus.pipe_valid = 1'b0; bus.pipe_data = '0;

    // Reset holds grant off even with a pending request.
    rst = 1'b0;
    tick(1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick(1'b1, 1'b0);
      chk("rst_grant", s_grant, 0);
      chk("rst_valid", s_valid, 0);
      chk("rst_count", s_count, 0);
      chk("rst_infl",  s_infl, 0);
      chk("rst_err",   s_err, 0);
    end
    rst = 1'b1;
    tick(1'b1, 1'b0);
    chk("rel_grant", s_grant, 1);
    chk("rel_credits", s_credits, DEP);
    do_reset();
    inv_en = 1'b1;

    // Single-item table.
    for (int i = 0; i < 7; i++) begin
      tick(tbl[i].req, tbl[i].rdy);
      chk($sformatf("tbl%0d_grant", i), s_grant, tbl[i].grant);
      chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_count", i), s_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_infl", i),  s_infl,  tbl[i].infl);
    end
    chk("single_credits", s_credits, DEP);
    chk("single_sb_empty", sb.size(), 0);

    // Fill with consumer stalled: exactly DEP grants, then full.
    g0 = n_grant;
    repeat (20) tick(1'b1, 1'b0);
    chk("fill_grants", n_grant - g0, DEP);
    tick(1'b1, 1'b0);
    chk("fill_grant_off", s_grant, 0);
    chk("fill_count", s_count, DEP);
    chk("fill_infl", s_infl, 0);
    chk("fill_err", s_err, 0);
    tick(1'b1, 1'b1);
    g0 = n_grant;
    repeat (6) tick(1'b1, 1'b0);
    chk("refill_one_grant", n_grant - g0, 1);
    chk("refill_count", s_count, DEP);
    repeat (20) tick(1'b0, 1'b1);
    chk("drain_sb", sb.size(), 0);
    chk("drain_count", s_count, 0);

    // Streaming 100 items at full rate with simultaneous grant/push/pop.
    g0 = n_grant; out0 = n_out; c0 = 0;
    while ((n_grant - g0) < 100 && c0 < 300) begin
      tick(1'b1, 1'b1);
      c0++;
      if (s_grant && s_pop) chk("gp_credits_hold", post_credits, s_credits);
      if (s_push && s_pop)  chk("pp_count_hold", post_count, s_count);
    end
    chk("stream_grants", n_grant - g0, 100);
    chk("stream_cycles", c0, 100);
    c0 = 0;
    while (sb.size() != 0 && c0 < 40) begin
      tick(1'b0, 1'b1);
      c0++;
    end
    chk("stream_outputs", n_out - out0, 100);
    chk("stream_sb_empty", sb.size(), 0);
    chk("stream_err", bus.err, 0);

    // Spurious item with nothing in flight: sticky error until reset.
    inv_en = 1'b0;
    force_pv = 1'b1;
    tick(1'b0, 1'b0);
    chk("spur_pre_infl", s_infl, 0);
    force_pv = 1'b0;
    tick(1'b0, 1'b0);
    chk("spur_err", s_err, 1);
    chk("spur_infl", s_infl, 0);
    repeat (3) tick(1'b0, 1'b0);
    chk("spur_sticky", s_err, 1);
    rst = 1'b0;
    tick(1'b0, 1'b0);
    rst = 1'b1;
    tick(1'b0, 1'b0);
    chk("rst_clears_err", s_err, 0);
    chk("rst_clears_count", s_count, 0);
    chk("rst_credits", s_credits, DEP);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/srl_credit_fifo.md
# srl_credit_fifo

Credit-gated output buffer that sits directly downstream of a fixed-latency shift-register delay line with no backpressure. It grants upstream issue slots only when buffer space is guaranteed for every item already in flight, then captures what the pipeline produces and presents it on a valid/ready interface. This lets a stall-free delay pipeline feed a consumer that can stall.

## Interface
- C_DATA_WIDTH, 32, payload width.
- C_FIFO_DEPTH, 16, buffer entries; power of two; must be ≥ C_PIPE_LATENCY + 1.
- C_PIPE_LATENCY, 4, documented delay of the upstream pipeline; used only for the depth check; no functional effect.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (rst == 0 resets on the next rising clk edge).
- issue_req  in  1  upstream requests to launch one item into the pipeline this cycle.
- issue_grant  out  1  item launch permitted this cycle; combinational: issue_req && (credits != 0) && rst.
- pipe_valid  in  1  pipeline output carries a valid item this cycle.
- pipe_data  in  C_DATA_WIDTH  pipeline output payload.
- out_valid  out  1  buffer non-empty.
- out_ready  in  1  consumer accepts the head item.
- out_data  out  C_DATA_WIDTH  head item; first-word-fall-through.
- count  out  $clog2(C_FIFO_DEPTH+1)  current occupancy.
- in_flight  out  $clog2(C_FIFO_DEPTH+1)  granted items not yet received.
- err  out  1  sticky protocol error.

## Operation
- Storage: C_FIFO_DEPTH × C_DATA_WIDTH memory, wr_ptr/rd_ptr of log2(depth) bits, wrapping naturally at depth; separate occupancy counter (no pointer-compare full/empty).
- credits = C_FIFO_DEPTH − count − in_flight, held as its own register; reset value C_FIFO_DEPTH.
- push = pipe_valid && (count != C_FIFO_DEPTH); pop = out_valid && out_ready.
- grant = issue_grant. Credit update: grant without pop → −1; pop without grant → +1; both or neither → unchanged.
- in_flight update: grant without pipe_valid → +1; pipe_valid without grant → −1; both → unchanged.
- count update: push without pop → +1; pop without push → −1; both → unchanged (write and read of different slots; a push into an empty buffer is not visible on out_data until the next cycle).
- err set (sticky until reset) when: pipe_valid && in_flight == 0 (spurious item), or pipe_valid && count == C_FIFO_DEPTH (overflow; data dropped, pointers unchanged), or in_flight saturating at C_FIFO_DEPTH with another grant (cannot occur while credits are correct).
- An item with pipe_valid == 1 on a cycle with err detection is still counted against in_flight only if in_flight != 0 (no underflow wrap).
- Invariant checked by the bench: credits + count + in_flight == C_FIFO_DEPTH every cycle.
- Elaboration: depth not a power of two, or depth < C_PIPE_LATENCY + 1 → $error.

## Timing
- Reset (rst == 0 at edge): count=0, in_flight=0, credits=C_FIFO_DEPTH, pointers=0, err=0; out_valid=0; issue_grant forced 0 while rst == 0. out_data unspecified (memory not cleared).
- Reset mid-operation discards buffered and in-flight items. Items emerging from the pipeline after reset release raise err; the integrating stage must also reset the pipeline.
- pipe_valid at edge t → out_valid=1 and out_data valid after edge t (visible in cycle t+1) if the buffer was empty.
- Pop at edge t → next entry is on out_data in cycle t+1; back-to-back pops at 1 item/cycle.
- Credit returned by pop at edge t → issue_grant can assert in cycle t+1.
- Sustained throughput is 1 item/cycle when C_FIFO_DEPTH ≥ C_PIPE_LATENCY + 1 and out_ready is held at 1.

## Test plan
- Reset: hold rst=0 for 2 cycles with issue_req=1 → issue_grant=0, out_valid=0, count=0, in_flight=0, err=0; after release, issue_grant=1 on the first cycle.
- Single item: grant at cycle 0, pipe_valid with pipe_data=0xA5A5_0001 at cycle 4 → out_valid=1 and out_data=0xA5A5_0001 at cycle 5; pop → count=0, credits=16.
- Fill with stall: out_ready=0, issue_req=1 continuously → exactly 16 grants, then issue_grant=0; after 4-cycle latency count=16, in_flight=0, err=0; one pop → exactly one further grant.
- Streaming: depth 16, latency 4, out_ready=1, issue_req=1 for 100 cycles → 100 grants, 100 items out in order, invariant holds every cycle, err=0.
- Simultaneous events: grant+pop and push+pop in the same cycle → credits and count unchanged, data order preserved across rd_ptr/wr_ptr wrap at 15→0.
- Errors: pipe_valid with in_flight=0 → err=1 next cycle, in_flight stays 0; err remains 1 until rst=0, then clears.
